// File: rtl/prog_loader.sv
// Framed byte-stream loader feeding the program ROM write port; holds the core off while a frame is in flight.
// Optional inter-byte timeout is built when PROG_LOADER_TIMEOUT_EN is defined.
module prog_loader #(
  parameter int unsigned ADDR_W         = 15,
  parameter logic [7:0]  SYNC_BYTE      = 8'hA5,
  parameter logic        HOLD_AT_RESET  = 1'b0,
  parameter logic [15:0] TIMEOUT_CYCLES = 16'd50000
) (
  input  logic              clk,
  input  logic              clr_n,
  input  logic [7:0]        in_data,
  input  logic              in_valid,
  output logic              in_ready,
  input  logic              err_clr,
  output logic [7:0]        data,
  output logic [ADDR_W-1:0] write_addr,
  output logic              WE,
  output logic              cpu_hold,
  output logic              done,
  output logic              err_csum,
  output logic              err_timeout
);

  typedef enum logic [2:0] {
    ST_IDLE,
    ST_ADDR_H,
    ST_ADDR_L,
    ST_LEN_H,
    ST_LEN_L,
    ST_PAYLOAD,
    ST_CSUM,
    ST_ERR
  } state_t;

  state_t            state_q, state_d;
  logic [ADDR_W-1:0] base_q;
  logic [15:0]       len_q;
  logic [15:0]       offset_q;
  logic [7:0]        sum_q;
  logic [7:0]        csum_total;
  logic [15:0]       len_full;
  logic              accept;
  logic              is_sync;
  logic              last_byte;
  logic              timeout_hit;

  assign in_ready   = (state_q != ST_ERR);
  assign accept     = in_valid & in_ready;
  assign is_sync    = (in_data == SYNC_BYTE);
  assign csum_total = sum_q + in_data;
  assign len_full   = {len_q[15:8], in_data};
  assign last_byte  = ((offset_q + 16'd1) == len_q);

`ifdef PROG_LOADER_TIMEOUT_EN
  logic        in_frame;
  logic [15:0] stall_cnt;

  assign in_frame    = (state_q != ST_IDLE) && (state_q != ST_ERR);
  // The edge on which the count would reach the limit is the timeout edge itself.
  assign timeout_hit = in_frame && !accept && (stall_cnt == (TIMEOUT_CYCLES - 16'd1));

  always_ff @(posedge clk or negedge clr_n) begin
    if (!clr_n) begin
      stall_cnt <= '0;
    end else if (!in_frame || accept || timeout_hit) begin
      stall_cnt <= '0;
    end else begin
      stall_cnt <= stall_cnt + 16'd1;
    end
  end
`else
  logic unused_timeout_cfg;

  assign unused_timeout_cfg = ^TIMEOUT_CYCLES;
  assign timeout_hit        = 1'b0;
`endif

  always_ff @(posedge clk or negedge clr_n) begin
    if (!clr_n) begin
      state_q <= ST_IDLE;
    end else begin
      state_q <= state_d;
    end
  end

  always_comb begin
    state_d = state_q;
    if (timeout_hit) begin
      state_d = ST_ERR;
    end else begin
      case (state_q)
        ST_IDLE:    if (accept && is_sync) state_d = ST_ADDR_H;
        ST_ADDR_H:  if (accept) state_d = ST_ADDR_L;
        ST_ADDR_L:  if (accept) state_d = ST_LEN_H;
        ST_LEN_H:   if (accept) state_d = ST_LEN_L;
        ST_LEN_L:   if (accept) state_d = (len_full != 16'd0) ? ST_PAYLOAD : ST_CSUM;
        ST_PAYLOAD: if (accept && last_byte) state_d = ST_CSUM;
        ST_CSUM:    if (accept) state_d = (csum_total == 8'h00) ? ST_IDLE : ST_ERR;
        ST_ERR:     if (err_clr) state_d = ST_IDLE;
        default:    state_d = ST_IDLE;
      endcase
    end
  end

  always_ff @(posedge clk or negedge clr_n) begin
    if (!clr_n) begin
      base_q      <= '0;
      len_q       <= '0;
      offset_q    <= '0;
      sum_q       <= '0;
      data        <= '0;
      write_addr  <= '0;
      WE          <= 1'b0;
      done        <= 1'b0;
      err_csum    <= 1'b0;
      err_timeout <= 1'b0;
      cpu_hold    <= HOLD_AT_RESET;
    end else begin
      WE   <= 1'b0;
      done <= 1'b0;

      if (accept) begin
        // Every byte after the sync, the checksum byte included, joins the running sum.
        if (state_q != ST_IDLE) begin
          sum_q <= csum_total;
        end
        case (state_q)
          ST_IDLE: begin
            if (is_sync) begin
              cpu_hold <= 1'b1;
              sum_q    <= '0;
            end
          end
          ST_ADDR_H:  base_q      <= ADDR_W'({in_data, 8'h00});
          ST_ADDR_L:  base_q[7:0] <= in_data;
          ST_LEN_H:   len_q[15:8] <= in_data;
          ST_LEN_L: begin
            len_q[7:0] <= in_data;
            offset_q   <= '0;
          end
          ST_PAYLOAD: begin
            data       <= in_data;
            write_addr <= base_q + ADDR_W'(offset_q);
            WE         <= 1'b1;
            offset_q   <= offset_q + 16'd1;
          end
          ST_CSUM: begin
            if (csum_total == 8'h00) begin
              done     <= 1'b1;
              cpu_hold <= 1'b0;
            end else begin
              err_csum <= 1'b1;
            end
          end
          default: ;
        endcase
      end

      if (timeout_hit) begin
        err_timeout <= 1'b1;
      end

      if ((state_q == ST_ERR) && err_clr) begin
        err_csum    <= 1'b0;
        err_timeout <= 1'b0;
      end
    end
  end

endmodule
